tfhe_axi_slave_mem: RTL and testbench



---
 rtl/tfhe_axi_slave_mem.sv | 199 +++++++++++++++++++
 tb/tb_tfhe_axi_slave_mem.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tfhe_axi_slave_mem.sv
// AXI4 INCR-burst slave in front of a byte-strobed on-chip memory. Read and write
// paths run as independent FSMs with one outstanding burst each; out-of-range beats get SLVERR.
module tfhe_axi_slave_mem #(
    parameter int          C_S_AXI_ID_WIDTH   = 1,
    parameter int          C_S_AXI_ADDR_WIDTH = 64,
    parameter int          C_S_AXI_DATA_WIDTH = 256,
    parameter logic [63:0] C_S_BASE_ADDR      = 64'h4000_0000,
    parameter int          C_MEM_DEPTH        = 1024
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]                      S_AXI_AWLEN,
    input  logic [2:0]                      S_AXI_AWSIZE,
    input  logic [1:0]                      S_AXI_AWBURST,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WLAST,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]                      S_AXI_ARLEN,
    input  logic [2:0]                      S_AXI_ARSIZE,
    input  logic [1:0]                      S_AXI_ARBURST,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RLAST,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);
    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(C_MEM_DEPTH);
    localparam logic [C_S_AXI_ADDR_WIDTH-1:0] BASE  = C_S_AXI_ADDR_WIDTH'(C_S_BASE_ADDR);
    localparam logic [C_S_AXI_ADDR_WIDTH-1:0] DEPTH = C_S_AXI_ADDR_WIDTH'(C_MEM_DEPTH);
    localparam logic [C_S_AXI_ADDR_WIDTH-1:0] ONE   = C_S_AXI_ADDR_WIDTH'(1);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_SEND} r_state_t;

    w_state_t                      w_state;
    r_state_t                      r_state;
    logic [C_S_AXI_ADDR_WIDTH-1:0] w_idx, r_idx;
    logic                          w_base_ok, r_base_ok;
    logic [7:0]                    w_len, w_cnt, r_len, r_cnt;
    logic                          w_err;

    logic [C_S_AXI_DATA_WIDTH-1:0] mem [C_MEM_DEPTH];

    // Indices keep the full address width so a burst running off the end stays out of range.
    logic [C_S_AXI_ADDR_WIDTH-1:0] aw_idx, ar_idx;
    logic aw_base_ok, ar_base_ok;
    assign aw_idx     = (S_AXI_AWADDR - BASE) >> OFF_W;
    assign ar_idx     = (S_AXI_ARADDR - BASE) >> OFF_W;
    assign aw_base_ok = (S_AXI_AWADDR >= BASE);
    assign ar_base_ok = (S_AXI_ARADDR >= BASE);

    logic w_in_range, r_in_range, w_fire, w_last_beat, beat_err, mem_we;
    assign w_in_range  = w_base_ok && (w_idx < DEPTH);
    assign r_in_range  = r_base_ok && (r_idx < DEPTH);
    assign w_fire      = S_AXI_WVALID && S_AXI_WREADY;
    assign w_last_beat = (w_cnt == w_len);
    assign beat_err    = !w_in_range || (S_AXI_WLAST != w_last_beat);
    assign mem_we      = w_fire && w_in_range;

    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_ARSIZE, S_AXI_ARBURST};

    always_ff @(posedge S_AXI_ACLK) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (S_AXI_WSTRB[b])
                    mem[w_idx[IDX_W-1:0]][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_state       <= W_IDLE;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= 2'b00;
            S_AXI_BID     <= '0;
            w_idx         <= '0;
            w_base_ok     <= 1'b0;
            w_len         <= 8'd0;
            w_cnt         <= 8'd0;
            w_err         <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (S_AXI_AWVALID && S_AXI_AWREADY) begin
                        S_AXI_BID     <= S_AXI_AWID;
                        w_idx         <= aw_idx;
                        w_base_ok     <= aw_base_ok;
                        w_len         <= S_AXI_AWLEN;
                        w_cnt         <= 8'd0;
                        w_err         <= 1'b0;
                        S_AXI_AWREADY <= 1'b0;
                        S_AXI_WREADY  <= 1'b1;
                        w_state       <= W_DATA;
                    end else begin
                        S_AXI_AWREADY <= 1'b1;
                    end
                end
                // The beat count alone ends the burst; a wrong WLAST only poisons the response.
                W_DATA: begin
                    if (w_fire) begin
                        if (w_last_beat) begin
                            S_AXI_WREADY <= 1'b0;
                            S_AXI_BVALID <= 1'b1;
                            S_AXI_BRESP  <= (w_err || beat_err) ? 2'b10 : 2'b00;
                            w_state      <= W_RESP;
                        end else begin
                            w_err <= w_err || beat_err;
                            w_cnt <= w_cnt + 8'd1;
                            w_idx <= w_idx + ONE;
                        end
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        S_AXI_BVALID  <= 1'b0;
                        S_AXI_AWREADY <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state       <= R_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RLAST   <= 1'b0;
            S_AXI_RRESP   <= 2'b00;
            S_AXI_RID     <= '0;
            S_AXI_RDATA   <= '0;
            r_idx         <= '0;
            r_base_ok     <= 1'b0;
            r_len         <= 8'd0;
            r_cnt         <= 8'd0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                        S_AXI_RID     <= S_AXI_ARID;
                        r_idx         <= ar_idx;
                        r_base_ok     <= ar_base_ok;
                        r_len         <= S_AXI_ARLEN;
                        r_cnt         <= 8'd0;
                        S_AXI_ARREADY <= 1'b0;
                        r_state       <= R_FETCH;
                    end else begin
                        S_AXI_ARREADY <= 1'b1;
                    end
                end
                R_FETCH: begin
                    S_AXI_RDATA  <= r_in_range ? mem[r_idx[IDX_W-1:0]] : '0;
                    S_AXI_RRESP  <= r_in_range ? 2'b00 : 2'b10;
                    S_AXI_RLAST  <= (r_cnt == r_len);
                    S_AXI_RVALID <= 1'b1;
                    r_state      <= R_SEND;
                end
                R_SEND: begin
                    if (S_AXI_RREADY) begin
                        S_AXI_RVALID <= 1'b0;
                        if (S_AXI_RLAST) begin
                            S_AXI_RLAST   <= 1'b0;
                            S_AXI_ARREADY <= 1'b1;
                            r_state       <= R_IDLE;
                        end else begin
                            r_cnt   <= r_cnt + 8'd1;
                            r_idx   <= r_idx + ONE;
                            r_state <= R_FETCH;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tfhe_axi_slave_mem.sv
// Directed bench for tfhe_axi_slave_mem: table-driven write/read vectors plus
// hand-written sequences for stalls, simultaneous access and mid-burst reset.
`timescale 1ns/1ps
module tb_tfhe_axi_slave_mem;
    localparam logic [63:0] BASE = 64'h4000_0000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [0:0]   awid, bid, arid, rid;
    logic [63:0]  awaddr, araddr;
    logic [7:0]   awlen, arlen;
    logic [2:0]   awsize, arsize;
    logic [1:0]   awburst, arburst, bresp, rresp;
    logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rlast, rvalid, rready;
    logic [255:0] wdata, rdata;
    logic [31:0]  wstrb;

    int checks = 0;
    int errors = 0;

    logic [255:0] got_data [16];
    logic [1:0]   got_resp [16];
    logic         got_last [16];

    typedef struct {
        logic [63:0]  addr;
        int           len;
        logic         id;
        logic [31:0]  strb;
        bit           beat_data;
        logic [255:0] fill;
        int           last_beat;
        int           b_delay;
        logic [1:0]   exp_b;
    } wvec_t;

    typedef struct {
        logic [63:0]       addr;
        int                len;
        logic              id;
        logic [3:0][255:0] d;
        logic [3:0][1:0]   r;
    } rvec_t;

    wvec_t wv [6];
    rvec_t rv [6];

    always #5 clk = ~clk;

    tfhe_axi_slave_mem dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize),
        .S_AXI_AWBURST(awburst), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast), .S_AXI_WVALID(wvalid),
        .S_AXI_WREADY(wready),
        .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(arsize),
        .S_AXI_ARBURST(arburst), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
        .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
    );

    task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_burst(input wvec_t v, input string tag);
        int waits;
        awaddr = v.addr; awlen = 8'(v.len); awid = v.id; awvalid = 1'b1;
        waits = 0;
        while (!awready && waits < 50) begin tick(); waits++; end
        check_output({tag, " aw_wait"}, 256'(waits), 256'(0));
        tick();
        awvalid = 1'b0;
        for (int i = 0; i <= v.len; i++) begin
            wdata = v.beat_data ? v.fill + 256'(i) : v.fill;
            wstrb = v.strb; wlast = (i == v.last_beat); wvalid = 1'b1;
            waits = 0;
            while (!wready && waits < 50) begin tick(); waits++; end
            check_output($sformatf("%s w_wait beat %0d", tag, i), 256'(waits), 256'(0));
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0;
        waits = 0;
        while (!bvalid && waits < 50) begin tick(); waits++; end
        check_output({tag, " b_latency"}, 256'(waits), 256'(0));
        check_output({tag, " bresp"}, 256'(bresp), 256'(v.exp_b));
        check_output({tag, " bid"}, 256'(bid), 256'(v.id));
        for (int k = 0; k < v.b_delay; k++) begin
            tick();
            check_output($sformatf("%s bvalid_hold %0d", tag, k), 256'(bvalid), 256'(1));
            check_output($sformatf("%s bresp_hold %0d", tag, k), 256'(bresp), 256'(v.exp_b));
            check_output($sformatf("%s bid_hold %0d", tag, k), 256'(bid), 256'(v.id));
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check_output({tag, " bvalid_clear"}, 256'(bvalid), 256'(0));
        check_output({tag, " awready_back"}, 256'(awready), 256'(1));
    endtask

    task automatic read_burst(input logic [63:0] addr, input int len, input logic id,
                              input int stall_beat, input int stall_cycles, input string tag);
        int waits;
        araddr = addr; arlen = 8'(len); arid = id; arvalid = 1'b1; rready = 1'b0;
        waits = 0;
        while (!arready && waits < 50) begin tick(); waits++; end
        check_output({tag, " ar_wait"}, 256'(waits), 256'(0));
        tick();
        arvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            waits = 0;
            while (!rvalid && waits < 50) begin tick(); waits++; end
            check_output($sformatf("%s r_latency beat %0d", tag, i), 256'(waits), 256'(1));
            if (!rvalid) return;
            got_data[i] = rdata; got_resp[i] = rresp; got_last[i] = rlast;
            check_output($sformatf("%s rid beat %0d", tag, i), 256'(rid), 256'(id));
            if (i == stall_beat) begin
                for (int k = 0; k < stall_cycles; k++) begin
                    tick();
                    check_output($sformatf("%s rvalid_hold %0d", tag, k), 256'(rvalid), 256'(1));
                    check_output($sformatf("%s rdata_hold %0d", tag, k), rdata, got_data[i]);
                    check_output($sformatf("%s rresp_hold %0d", tag, k), 256'(rresp), 256'(got_resp[i]));
                    check_output($sformatf("%s rlast_hold %0d", tag, k), 256'(rlast), 256'(got_last[i]));
                end
            end
            rready = 1'b1;
            tick();
            rready = 1'b0;
        end
        check_output({tag, " arready_back"}, 256'(arready), 256'(1));
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, " awready"}, 256'(awready), 256'(0));
        check_output({tag, " wready"}, 256'(wready), 256'(0));
        check_output({tag, " bvalid"}, 256'(bvalid), 256'(0));
        check_output({tag, " arready"}, 256'(arready), 256'(0));
        check_output({tag, " rvalid"}, 256'(rvalid), 256'(0));
        check_output({tag, " rlast"}, 256'(rlast), 256'(0));
        check_output({tag, " bresp_rresp"}, 256'({bresp, rresp}), 256'(0));
        check_output({tag, " bid_rid"}, 256'({bid, rid}), 256'(0));
        check_output({tag, " rdata"}, rdata, 256'(0));
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog expired got running expected finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        wvec_t t1;
        awid = '0; awaddr = '0; awlen = '0; awsize = 3'd5; awburst = 2'b01; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = 3'd5; arburst = 2'b01; arvalid = 1'b0;
        rready = 1'b0;

        wv[0] = '{BASE,              0, 1'b0, 32'h0000_000F, 1'b0, '1,          0,  0, 2'b00};
        wv[1] = '{64'h4000_7FC0,     3, 1'b1, 32'hFFFF_FFFF, 1'b1, 256'h100,    3,  0, 2'b10};
        wv[2] = '{64'h4000_0280,     3, 1'b1, 32'hFFFF_FFFF, 1'b1, 256'h200,    1,  5, 2'b10};
        wv[3] = '{64'h4000_03C0,     1, 1'b0, 32'hFFFF_FFFF, 1'b1, 256'h300,    99, 0, 2'b10};
        wv[4] = '{64'h3FFF_FFE0,     0, 1'b1, 32'hFFFF_FFFF, 1'b0, 256'h77,     0,  0, 2'b10};
        wv[5] = '{64'h4000_0505,     0, 1'b0, 32'hFFFF_FFFF, 1'b0, 256'h55,     0,  2, 2'b00};

        for (int k = 0; k < 6; k++) begin rv[k].d = '0; rv[k].r = '0; end
        rv[0].addr = BASE;          rv[0].len = 1; rv[0].id = 1'b1;
        rv[0].d[0] = 256'hFFFF_FFFF; rv[0].d[1] = 256'h1;
        rv[1].addr = 64'h4000_7FC0; rv[1].len = 3; rv[1].id = 1'b0;
        rv[1].d[0] = 256'h100; rv[1].d[1] = 256'h101; rv[1].r[2] = 2'b10; rv[1].r[3] = 2'b10;
        rv[2].addr = 64'h4000_0280; rv[2].len = 3; rv[2].id = 1'b1;
        rv[2].d[0] = 256'h200; rv[2].d[1] = 256'h201; rv[2].d[2] = 256'h202; rv[2].d[3] = 256'h203;
        rv[3].addr = 64'h4000_03C0; rv[3].len = 1; rv[3].id = 1'b0;
        rv[3].d[0] = 256'h300; rv[3].d[1] = 256'h301;
        rv[4].addr = 64'h3FFF_FFE0; rv[4].len = 0; rv[4].id = 1'b1; rv[4].r[0] = 2'b10;
        rv[5].addr = 64'h4000_0500; rv[5].len = 0; rv[5].id = 1'b0; rv[5].d[0] = 256'h55;

        // Reset values and first-edge ready behaviour.
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        #1;
        check_output("awready_before_edge", 256'(awready), 256'(0));
        check_output("arready_before_edge", 256'(arready), 256'(0));
        tick();
        check_output("awready_first_edge", 256'(awready), 256'(1));
        check_output("arready_first_edge", 256'(arready), 256'(1));

        // 16-beat write then read back with an RREADY stall on beat 7.
        t1 = '{BASE, 15, 1'b1, 32'hFFFF_FFFF, 1'b1, 256'h0, 15, 0, 2'b00};
        write_burst(t1, "t1");
        read_burst(BASE, 15, 1'b0, 7, 3, "t1_rd");
        for (int i = 0; i < 16; i++) begin
            check_output($sformatf("t1 rdata %0d", i), got_data[i], 256'(i));
            check_output($sformatf("t1 rresp %0d", i), 256'(got_resp[i]), 256'(0));
            check_output($sformatf("t1 rlast %0d", i), 256'(got_last[i]), 256'(i == 15));
        end

        for (int k = 0; k < 6; k++)
            write_burst(wv[k], $sformatf("wv%0d", k));

        for (int k = 0; k < 6; k++) begin
            read_burst(rv[k].addr, rv[k].len, rv[k].id, -1, 0, $sformatf("rv%0d", k));
            for (int b = 0; b <= rv[k].len; b++) begin
                check_output($sformatf("rv%0d rdata %0d", k, b), got_data[b], rv[k].d[b]);
                check_output($sformatf("rv%0d rresp %0d", k, b), 256'(got_resp[b]), 256'(rv[k].r[b]));
                check_output($sformatf("rv%0d rlast %0d", k, b), 256'(got_last[b]), 256'(b == rv[k].len));
            end
        end

        // Simultaneous write and read of word 5: the read must see the old value.
        awaddr = 64'h4000_00A0; awlen = 8'd0; awid = 1'b1; awvalid = 1'b1;
        araddr = 64'h4000_00A0; arlen = 8'd0; arid = 1'b1; arvalid = 1'b1;
        wdata = 256'hAAAA; wstrb = '1; wlast = 1'b1; wvalid = 1'b1;
        check_output("sim awready", 256'(awready), 256'(1));
        check_output("sim arready", 256'(arready), 256'(1));
        tick();
        awvalid = 1'b0; arvalid = 1'b0;
        check_output("sim wready", 256'(wready), 256'(1));
        tick();
        wvalid = 1'b0; wlast = 1'b0;
        check_output("sim rvalid", 256'(rvalid), 256'(1));
        check_output("sim rdata_old", rdata, 256'h5);
        check_output("sim rlast", 256'(rlast), 256'(1));
        check_output("sim bvalid", 256'(bvalid), 256'(1));
        check_output("sim bresp", 256'(bresp), 256'(0));
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
        check_output("sim bvalid_clear", 256'(bvalid), 256'(0));
        check_output("sim rvalid_clear", 256'(rvalid), 256'(0));
        read_burst(64'h4000_00A0, 0, 1'b1, -1, 0, "sim_rd");
        check_output("sim rdata_new", got_data[0], 256'hAAAA);

        // Reset asserted while beat 5 of a 16-beat write is on the bus.
        awaddr = 64'h4000_0C80; awlen = 8'd15; awid = 1'b1; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wdata = 256'h400 + 256'(i); wstrb = '1; wlast = 1'b0; wvalid = 1'b1;
            check_output($sformatf("rst wready beat %0d", i), 256'(wready), 256'(1));
            tick();
        end
        wdata = 256'h405;
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        wvalid = 1'b0;
        repeat (2) tick();
        check_output("mid_reset bvalid_held", 256'(bvalid), 256'(0));
        rst_n = 1'b1;
        #1;
        check_output("release awready_before_edge", 256'(awready), 256'(0));
        tick();
        check_output("release awready_first_edge", 256'(awready), 256'(1));
        check_output("release bvalid", 256'(bvalid), 256'(0));
        read_burst(64'h4000_0C80, 4, 1'b0, -1, 0, "rst_rd");
        for (int i = 0; i < 5; i++)
            check_output($sformatf("rst rdata %0d", i), got_data[i], 256'h400 + 256'(i));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
